// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, image geometry and scan-out state encoding.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int IMG_X0_DEF   = 192;
    localparam int IMG_Y0_DEF   = 112;

    localparam int IMG_SIZE = 256;
    localparam int CNT_W    = 10;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 17;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/vga_timing_counter.sv
// Free-running horizontal/vertical raster counter pair with a frame-wrap flag.
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic h_last;
    logic v_last;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);
    assign wrap   = enable && h_last && v_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (enable) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_scanout.sv
// 640x480 VGA scan-out of a 256x256 grayscale image with two selectable banks
// and a two-stage output pipeline matched to a 1-cycle registered framebuffer.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int IMG_X0   = IMG_X0_DEF,
    parameter int IMG_Y0   = IMG_Y0_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              image_select,
    input  logic [DATA_W-1:0] pix_data,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              hsync,
    output logic              vsync,
    output logic [23:0]       rgb_out,
    output logic              frame_done
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] HS_LO = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_HI = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_LO = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_HI = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // One extra bit so the window end (origin + 256) cannot overflow.
    localparam logic [CNT_W:0] X_LO = (CNT_W + 1)'(IMG_X0);
    localparam logic [CNT_W:0] X_HI = (CNT_W + 1)'(IMG_X0 + IMG_SIZE);
    localparam logic [CNT_W:0] Y_LO = (CNT_W + 1)'(IMG_Y0);
    localparam logic [CNT_W:0] Y_HI = (CNT_W + 1)'(IMG_Y0 + IMG_SIZE);
    localparam logic [7:0]     X_OFF = 8'(IMG_X0);
    localparam logic [7:0]     Y_OFF = 8'(IMG_Y0);

    function automatic logic [23:0] gray_to_rgb(input logic [DATA_W-1:0] g);
        return {g, g, g};
    endfunction

    state_t            state_q;
    state_t            state_d;
    logic              run;
    logic              bank;
    logic              frame_wrap;
    logic [CNT_W-1:0]  h_cnt;
    logic [CNT_W-1:0]  v_cnt;
    logic              in_image;
    logic              hs_raw;
    logic              vs_raw;
    logic [7:0]        h_off;
    logic [7:0]        v_off;
    logic [ADDR_W-1:0] img_addr;

    logic [ADDR_W-1:0] addr_p1;
    logic              img_p1, vld_p1, hs_p1, vs_p1, done_p1;
    logic              img_p2, vld_p2, hs_p2, vs_p2, done_p2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    assign run = (state_q == RUN);

    vga_timing_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_counter (
        .clk    (clk),
        .rst_n  (rst),
        .enable (run),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .wrap   (frame_wrap)
    );

    // Bank only changes where a frame begins, so a frame never mixes banks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            bank <= 1'b0;
        else if ((state_q == IDLE && start) || frame_wrap)
            bank <= image_select;
    end

    assign in_image = run
                   && ({1'b0, h_cnt} >= X_LO) && ({1'b0, h_cnt} < X_HI)
                   && ({1'b0, v_cnt} >= Y_LO) && ({1'b0, v_cnt} < Y_HI);
    assign h_off    = h_cnt[7:0] - X_OFF;
    assign v_off    = v_cnt[7:0] - Y_OFF;
    assign img_addr = {bank, v_off, h_off};
    assign hs_raw   = !(run && h_cnt >= HS_LO && h_cnt <= HS_HI);
    assign vs_raw   = !(run && v_cnt >= VS_LO && v_cnt <= VS_HI);

    // Stage 1: address to the framebuffer plus raw timing flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_p1 <= '0;
            img_p1  <= 1'b0;
            vld_p1  <= 1'b0;
            hs_p1   <= 1'b1;
            vs_p1   <= 1'b1;
            done_p1 <= 1'b0;
        end else begin
            if (in_image) addr_p1 <= img_addr;
            img_p1  <= in_image;
            vld_p1  <= run;
            hs_p1   <= hs_raw;
            vs_p1   <= vs_raw;
            done_p1 <= frame_wrap;
        end
    end

    // Stage 2: outputs, aligned with pixel data returned by the framebuffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            img_p2  <= 1'b0;
            vld_p2  <= 1'b0;
            hs_p2   <= 1'b1;
            vs_p2   <= 1'b1;
            done_p2 <= 1'b0;
        end else begin
            img_p2  <= img_p1;
            vld_p2  <= vld_p1;
            hs_p2   <= hs_p1;
            vs_p2   <= vs_p1;
            done_p2 <= done_p1;
        end
    end

    // The framebuffer's read register is the stage-2 data register.
    assign pix_addr   = addr_p1;
    assign rgb_out    = (vld_p2 && img_p2) ? gray_to_rgb(pix_data) : 24'h0;
    assign hsync      = hs_p2;
    assign vsync      = vs_p2;
    assign frame_done = done_p2;

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, IMG_X0 192, IMG_Y0 112; image size fixed at 256x256.
REQ-002 SHALL have ports, in this order:
- clk  in  1  single clock, pixel clock (25 MHz)
- rst  in  1  asynchronous, active-low reset
- start  in  1  level; leaves IDLE when high
- image_select  in  1  selects image bank 0/1
- pix_data  in  8  grayscale pixel from framebuffer RAM, valid 1 cycle after pix_addr
- pix_addr  out  17  framebuffer read address
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- rgb_out  out  24  pixel colour {R,G,B}
- frame_done  out  1  one-cycle pulse at frame wrap

Function
REQ-003 SHALL implement FSM states IDLE and RUN; IDLE -> RUN when start=1 sampled on a rising clk edge; RUN has no exit except reset.
REQ-004 In IDLE, h_cnt=0, v_cnt=0, hsync=1, vsync=1, rgb_out=0, pix_addr=0, frame_done=0.
REQ-005 In RUN, h_cnt SHALL count 0..799 and wrap to 0; v_cnt SHALL increment only when h_cnt wraps, count 0..524, then wrap to 0.
REQ-006 The first RUN cycle SHALL have h_cnt=0, v_cnt=0.
REQ-007 Bank register SHALL load image_select on the IDLE->RUN transition and when (h_cnt,v_cnt)=(799,524); it SHALL hold at all other times (no mid-frame tearing).
REQ-008 Image region: IMG_X0<=h_cnt<IMG_X0+256 and IMG_Y0<=v_cnt<IMG_Y0+256.
REQ-009 pix_addr SHALL be registered as {bank, (v_cnt-IMG_Y0)[7:0], (h_cnt-IMG_X0)[7:0]} when in image region, else hold its previous value.
REQ-010 Pipeline: stage 1 registers pix_addr, in_image, active, hsync_raw and vsync_raw from the counters; stage 2 registers the outputs. Every output SHALL therefore reflect counter state exactly 2 cycles earlier, mutually aligned.
REQ-011 hsync_raw SHALL be 0 iff 656<=h_cnt<=751; vsync_raw SHALL be 0 iff 490<=v_cnt<=491.
REQ-012 rgb_out SHALL be {pix_data,pix_data,pix_data} when the delayed in_image=1, else 24'h0, including throughout blanking.
REQ-013 frame_done SHALL pulse 1 for one cycle, aligned with the other outputs, for the pixel at (799,524).
REQ-014 Edge cases: start deasserted in RUN SHALL be ignored; an image_select change mid-frame SHALL take effect only at the next frame's first pixel.

Reset
REQ-015 rst=0 SHALL asynchronously force IDLE, zero all counters and pipeline registers, and set hsync=1, vsync=1, rgb_out=0, pix_addr=0, frame_done=0, bank=0.
REQ-016 Reset in the middle of a frame SHALL abort the frame without a frame_done pulse; after release the block SHALL wait for start in IDLE.

Structure
REQ-017 Timing constants and the state enum (IDLE, RUN) SHALL reside in a shared package, vga_pkg.
REQ-018 The h/v counter pair SHALL be a sub-module, vga_timing_counter (enable in; h_cnt, v_cnt and wrap out); the pipeline and FSM SHALL stay in vga_scanout.
REQ-019 The framebuffer RAM is external; the block SHALL model only its 1-cycle registered-read latency.

Verification
REQ-020 Hold start=0 for 1000 cycles -> hsync=vsync=1, rgb_out=0, pix_addr=0 throughout.
REQ-021 Pulse start, then run one frame -> 420000 cycles until the frame_done pulse; hsync low 96 cycles per line starting 658 cycles after the line's h_cnt=0 is entered; vsync low for 1600 cycles.
REQ-022 RAM model returns pix_data=addr[7:0] -> at counter (192,112), pix_addr=0x00000 with bank 0; 2 cycles later rgb_out=24'h000000; at (200,112), rgb_out=24'h080808; at (191,112) and (448,112), rgb_out=0.
REQ-023 image_select=1 asserted at (300,200) in frame 0 -> frame 0 addresses keep bit16=0; first image pixel of frame 1 gives pix_addr=0x10000.
REQ-024 rst=0 applied at (400,300) -> all outputs reach reset values within the same cycle, no frame_done pulse; after release with start=1, the first output sync edges follow the REQ-021 timing.
REQ-025 Last image pixel (447,367) -> pix_addr=0x0FFFF (bank 0); at (448,367) rgb_out=0 two cycles later.
